cordic_phase_sequencer: RTL and testbench

//  Front-end controller for the iterative CORDIC core and the offset-binary quarter selector.

---
 rtl/cordic_phase_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer: front-end sequencer for the iterative CORDIC
// core and offset-binary quarter selector; one phase in, one (x,y) out.
module cordic_phase_sequencer #(
    parameter int DATA_WIDTH  = 12,
    parameter int PHASE_WIDTH = 16,
    parameter int TIMEOUT     = 16,
    parameter int SEL_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHASE_WIDTH-1:0] in_phase,
    output logic                   core_start,
    output logic [PHASE_WIDTH-3:0] core_angle,
    input  logic                   core_done,
    output logic [1:0]             sel_quarter,
    input  logic [DATA_WIDTH:0]    sel_x,
    input  logic [DATA_WIDTH:0]    sel_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH:0]    out_x,
    output logic [DATA_WIDTH:0]    out_y,
    output logic                   out_err,
    output logic                   busy
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int SW = $clog2(SEL_LATENCY + 1) + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SEL_LAST   = SW'(SEL_LATENCY);

    localparam logic [DATA_WIDTH:0] MIDSCALE =
        {2'b01, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SEL,
        S_OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [TW-1:0] timer_q;
    logic [SW-1:0] sel_cnt_q;

    logic accept;
    logic clr_cnt;
    logic inc_timer;
    logic inc_sel;
    logic abort;
    logic capture;

    logic [1:0]             quadrant;
    logic [PHASE_WIDTH-3:0] frac;

    assign quadrant = in_phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
    assign frac     = in_phase[PHASE_WIDTH-3:0];

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign core_start = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_OUT);

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; core_done only counts in RUN.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        clr_cnt   = 1'b0;
        inc_timer = 1'b0;
        inc_sel   = 1'b0;
        abort     = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                clr_cnt = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_SEL;
                end else if (timer_q == TIMER_LAST) begin
                    abort   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    inc_timer = 1'b1;
                end
            end
            S_SEL: begin
                if (sel_cnt_q == SEL_LAST) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end else begin
                    inc_sel = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch, timers and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q     <= '0;
            sel_cnt_q   <= '0;
            core_angle  <= '0;
            sel_quarter <= 2'b00;
            out_x       <= MIDSCALE;
            out_y       <= MIDSCALE;
            out_err     <= 1'b0;
        end else begin
            if (accept) begin
                sel_quarter <= quadrant;
                core_angle  <= quadrant[0] ? ~frac : frac;
                out_err     <= 1'b0;
            end
            if (clr_cnt) begin
                timer_q   <= '0;
                sel_cnt_q <= '0;
            end
            if (inc_timer) begin
                timer_q <= timer_q + TW'(1);
            end
            if (inc_sel) begin
                sel_cnt_q <= sel_cnt_q + SW'(1);
            end
            if (abort) begin
                out_x   <= MIDSCALE;
                out_y   <= MIDSCALE;
                out_err <= 1'b1;
            end
            if (capture) begin
                out_x   <= sel_x;
                out_y   <= sel_y;
                out_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// tb_cordic_phase_sequencer: directed bench for the CORDIC
// front-end sequencer with hand-computed expectations.
module tb_cordic_phase_sequencer;

    localparam int DW = 12;
    localparam int PW = 16;
    localparam int TO = 16;
    localparam int SL = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_phase = '0;
    logic          core_start;
    logic [PW-3:0] core_angle;
    logic          core_done = 1'b0;
    logic [1:0]    sel_quarter;
    logic [DW:0]   sel_x = '0;
    logic [DW:0]   sel_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW:0]   out_x;
    logic [DW:0]   out_y;
    logic          out_err;
    logic          busy;

    int vecs = 0;
    int miss = 0;

    logic [15:0] t2_ph [4] = '{16'h4000, 16'hC001, 16'hA123, 16'h7FFF};
    logic [1:0]  t2_q  [4] = '{2'b01, 2'b11, 2'b10, 2'b01};
    logic [13:0] t2_a  [4] = '{14'h3FFF, 14'h3FFE, 14'h2123, 14'h0000};

    cordic_phase_sequencer #(
        .DATA_WIDTH (DW),
        .PHASE_WIDTH(PW),
        .TIMEOUT    (TO),
        .SEL_LATENCY(SL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_phase   (in_phase),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_done  (core_done),
        .sel_quarter(sel_quarter),
        .sel_x      (sel_x),
        .sel_y      (sel_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Accept one phase, pulse core_done in RUN cycle d (0 = never),
    // stop once out_valid is seen. lat counts edges after accept.
    task automatic run_txn(
        input  logic [15:0] phase,
        input  int          d,
        output int          lat,
        output int          starts,
        output logic [1:0]  q_load,
        output logic [13:0] a_load
    );
        lat    = -1;
        starts = 0;
        q_load = '0;
        a_load = '0;
        in_phase = phase;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (out_valid) begin
                lat = cyc;
                break;
            end
            if (core_start) begin
                starts++;
                q_load = sel_quarter;
                a_load = core_angle;
            end
            core_done = (d > 0 && cyc == d);
            tick();
            core_done = 1'b0;
        end
    endtask

    task automatic release_beat;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b1;
        core_done = 1'b1;
        tick();
        in_valid  = 1'b0;
        core_done = 1'b0;
        vecs++;
        if ({in_ready, busy, core_start, out_valid, out_err} !== 5'b10000) begin
            miss++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {in_ready, busy, core_start, out_valid, out_err});
        end
        vecs++;
        if (core_angle !== 14'h0 || sel_quarter !== 2'b00) begin
            miss++;
            $display("FAIL reset_req: got q=%b a=%h want q=00 a=0000",
                     sel_quarter, core_angle);
        end
        vecs++;
        if (out_x !== 13'h800 || out_y !== 13'h800) begin
            miss++;
            $display("FAIL reset_data: got x=%h y=%h want 800/800",
                     out_x, out_y);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        sel_x = 13'h1A5;
        sel_y = 13'h0F3;
        vecs++;
        if (in_ready !== 1'b1) begin
            miss++;
            $display("FAIL t1_ready: got %b want 1", in_ready);
        end
        run_txn(16'h0000, 12, lat, starts, q, a);
        vecs++;
        if (lat !== 15) begin
            miss++;
            $display("FAIL t1_latency: got %0d want 15", lat);
        end
        vecs++;
        if (starts !== 1) begin
            miss++;
            $display("FAIL t1_starts: got %0d want 1", starts);
        end
        vecs++;
        if (q !== 2'b00 || a !== 14'h0000) begin
            miss++;
            $display("FAIL t1_req: got q=%b a=%h want 00/0000", q, a);
        end
        vecs++;
        if (out_x !== 13'h1A5 || out_y !== 13'h0F3 || out_err !== 1'b0) begin
            miss++;
            $display("FAIL t1_beat: got x=%h y=%h e=%b want 1a5/0f3/0",
                     out_x, out_y, out_err);
        end
        release_beat();
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miss++;
            $display("FAIL t1_release: got v=%b r=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_quadrants;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        for (int i = 0; i < 4; i++) begin
            sel_x = 13'h100 + 13'(i);
            sel_y = 13'h0F0 - 13'(i);
            run_txn(t2_ph[i], 3, lat, starts, q, a);
            vecs++;
            if (q !== t2_q[i] || a !== t2_a[i]) begin
                miss++;
                $display("FAIL t2_req[%0d]: got q=%b a=%h want q=%b a=%h",
                         i, q, a, t2_q[i], t2_a[i]);
            end
            vecs++;
            if (sel_quarter !== t2_q[i] || core_angle !== t2_a[i]) begin
                miss++;
                $display("FAIL t2_hold[%0d]: got q=%b a=%h want q=%b a=%h",
                         i, sel_quarter, core_angle, t2_q[i], t2_a[i]);
            end
            vecs++;
            if (lat !== 6 || out_x !== 13'h100 + 13'(i)) begin
                miss++;
                $display("FAIL t2_beat[%0d]: got lat=%0d x=%h want 6/%h",
                         i, lat, out_x, 13'h100 + 13'(i));
            end
            release_beat();
        end
    endtask

    task automatic test_timeout;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        sel_x = 13'h1FFF;
        sel_y = 13'h0001;
        run_txn(16'h1234, 0, lat, starts, q, a);
        vecs++;
        if (lat !== TO + 1 || starts !== 1) begin
            miss++;
            $display("FAIL t3_latency: got lat=%0d starts=%0d want %0d/1",
                     lat, starts, TO + 1);
        end
        vecs++;
        if (out_err !== 1'b1 || out_x !== 13'h800 || out_y !== 13'h800) begin
            miss++;
            $display("FAIL t3_abort: got e=%b x=%h y=%h want 1/800/800",
                     out_err, out_x, out_y);
        end
        release_beat();
    endtask

    task automatic test_backpressure;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        sel_x = 13'h0AB;
        sel_y = 13'h1CD;
        run_txn(16'h8000, 5, lat, starts, q, a);
        vecs++;
        if (lat !== 8) begin
            miss++;
            $display("FAIL t4_latency: got %0d want 8", lat);
        end
        in_phase = 16'h4000;
        in_valid = 1'b1;
        sel_x    = 13'h000;
        sel_y    = 13'h000;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_x !== 13'h0AB || out_y !== 13'h1CD ||
                sel_quarter !== 2'b10) begin
                miss++;
                $display("FAIL t4_hold[%0d]: got v=%b r=%b x=%h y=%h q=%b want 1/0/0ab/1cd/10",
                         i, out_valid, in_ready, out_x, out_y, sel_quarter);
            end
        end
        in_valid = 1'b0;
        release_beat();
        vecs++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sel_quarter !== 2'b10) begin
            miss++;
            $display("FAIL t4_release: got r=%b v=%b q=%b want 1/0/10",
                     in_ready, out_valid, sel_quarter);
        end
    endtask

    task automatic test_done_edge;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        sel_x = 13'h0C3;
        sel_y = 13'h13C;
        run_txn(16'h2000, TO, lat, starts, q, a);
        vecs++;
        if (lat !== TO + 3 || out_err !== 1'b0) begin
            miss++;
            $display("FAIL t5_late_done: got lat=%0d e=%b want %0d/0",
                     lat, out_err, TO + 3);
        end
        vecs++;
        if (out_x !== 13'h0C3 || out_y !== 13'h13C) begin
            miss++;
            $display("FAIL t5_data: got x=%h y=%h want 0c3/13c", out_x, out_y);
        end
        release_beat();
        core_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (busy !== 1'b0 || core_start !== 1'b0 || out_valid !== 1'b0) begin
                miss++;
                $display("FAIL t5_stray[%0d]: got b=%b s=%b v=%b want 0/0/0",
                         i, busy, core_start, out_valid);
            end
        end
        core_done = 1'b0;
    endtask

    task automatic test_mid_reset;
        int lat, starts;
        logic [1:0]  q;
        logic [13:0] a;
        sel_x    = 13'h055;
        sel_y    = 13'h0AA;
        in_phase = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if ({in_ready, busy, core_start, out_valid, out_err} !== 5'b10000 ||
            core_angle !== 14'h0 || sel_quarter !== 2'b00 ||
            out_x !== 13'h800 || out_y !== 13'h800) begin
            miss++;
            $display("FAIL t6_run_reset: got ctl=%b a=%h q=%b x=%h y=%h want 10000/0000/00/800/800",
                     {in_ready, busy, core_start, out_valid, out_err},
                     core_angle, sel_quarter, out_x, out_y);
        end
        core_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (core_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miss++;
                $display("FAIL t6_quiet[%0d]: got s=%b v=%b b=%b want 0/0/0",
                         i, core_start, out_valid, busy);
            end
        end
        core_done = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_x !== 13'h800) begin
            miss++;
            $display("FAIL t6_sel_reset: got v=%b b=%b x=%h want 0/0/800",
                     out_valid, busy, out_x);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            miss++;
            $display("FAIL t6_no_beat: got v=%b want 0", out_valid);
        end
        sel_x = 13'h123;
        sel_y = 13'h321;
        run_txn(16'h5555, 2, lat, starts, q, a);
        vecs++;
        if (lat !== 5 || starts !== 1 || q !== 2'b01 || a !== 14'h2AAA) begin
            miss++;
            $display("FAIL t6_recover: got lat=%0d s=%0d q=%b a=%h want 5/1/01/2aaa",
                     lat, starts, q, a);
        end
        vecs++;
        if (out_x !== 13'h123 || out_y !== 13'h321 || out_err !== 1'b0) begin
            miss++;
            $display("FAIL t6_data: got x=%h y=%h e=%b want 123/321/0",
                     out_x, out_y, out_err);
        end
        release_beat();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_timeout();
        test_backpressure();
        test_done_edge();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
